// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, active-low digit patterns and the
// decode result / filter state types used by the capture path.
package seg7_pkg;

    // Bit positions within a 7-bit segment vector (a..g, MSB first)
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    // Active-low patterns; 6 and 9 use the tailed forms
    localparam logic [6:0] SEG7_0     = 7'h01;
    localparam logic [6:0] SEG7_1     = 7'h4F;
    localparam logic [6:0] SEG7_2     = 7'h12;
    localparam logic [6:0] SEG7_3     = 7'h06;
    localparam logic [6:0] SEG7_4     = 7'h4C;
    localparam logic [6:0] SEG7_5     = 7'h24;
    localparam logic [6:0] SEG7_6     = 7'h20;
    localparam logic [6:0] SEG7_7     = 7'h0F;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h04;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        KindDigit   = 2'd0,
        KindBlank   = 2'd1,
        KindInvalid = 2'd2
    } seg7_kind_e;

    typedef enum logic [1:0] {
        StIdle,
        StCommit,
        StHeld
    } seg7_filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier: active-low 7-segment pattern -> digit value, blank or invalid.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg7_kind_e kind,
    output logic [3:0] value
);

    always_comb begin
        kind  = KindDigit;
        value = 4'd0;
        case (pattern)
            SEG7_0:     value = 4'd0;
            SEG7_1:     value = 4'd1;
            SEG7_2:     value = 4'd2;
            SEG7_3:     value = 4'd3;
            SEG7_4:     value = 4'd4;
            SEG7_5:     value = 4'd5;
            SEG7_6:     value = 4'd6;
            SEG7_7:     value = 4'd7;
            SEG7_8:     value = 4'd8;
            SEG7_9:     value = 4'd9;
            SEG7_BLANK: kind  = KindBlank;
            default:    kind  = KindInvalid;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus:
// two-flop synchroniser, stability filter, one-hot select check and register bank.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd,
    output logic [IDX_W-1:0]        upd_idx
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned OW = NUM_DIGITS + 7;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] dig_s1, dig_s2;
    logic [OW-1:0]         obs, prev_obs_q, prev_obs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    seg7_filt_state_e      state_q, state_d;
    logic                  fire;
    logic                  one_hot;
    logic                  commit;
    logic [IDX_W-1:0]      idx;
    seg7_kind_e            kind;
    logic [3:0]            value;

    assign obs = {dig_s2, seg_s2};

    // Reset to all ones: no digit selected, all segments off
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1     <= '1;
            seg_s2     <= '1;
            dig_s1     <= '1;
            dig_s2     <= '1;
            prev_obs_q <= '1;
            cnt_q      <= '0;
            state_q    <= StIdle;
        end else begin
            seg_s1     <= seg_n;
            seg_s2     <= seg_s1;
            dig_s1     <= dig_n;
            dig_s2     <= dig_s1;
            prev_obs_q <= prev_obs_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        prev_obs_d = prev_obs_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        fire       = 1'b0;
        if (obs != prev_obs_q) begin
            prev_obs_d = obs;
            cnt_d      = CW'(1);
            state_d    = StIdle;
        end else if (state_q == StIdle) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
                fire    = 1'b1;
                state_d = StCommit;
            end
        end else begin
            // Saturated: a held pattern never re-commits
            state_d = StHeld;
        end
    end

    always_comb begin
        one_hot = $onehot(~dig_s2);
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!dig_s2[i]) idx = IDX_W'(i);
        end
    end

    assign commit = fire && one_hot;

    seg7_pattern_decode u_decode (
        .pattern (seg_s2),
        .kind    (kind),
        .value   (value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd         <= '0;
            digit_valid <= '0;
            blank       <= '0;
            err         <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
        end else begin
            upd <= commit;
            if (err_clr) err <= '0;
            // Later bit assignment lets a same-edge commit error win over err_clr
            if (commit) begin
                upd_idx <= idx;
                case (kind)
                    KindDigit: begin
                        bcd[{idx, 2'b00} +: 4] <= value;
                        digit_valid[idx]       <= 1'b1;
                        blank[idx]             <= 1'b0;
                    end
                    KindBlank: begin
                        blank[idx]       <= 1'b1;
                        digit_valid[idx] <= 1'b0;
                    end
                    default: begin
                        err[idx]         <= 1'b1;
                        digit_valid[idx] <= 1'b0;
                        blank[idx]       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed vectors plus a cycle model that derives
// commits from the history of sampled inputs.
module tb_seg7_capture;

    localparam int N = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         err_clr;
    logic [6:0]   seg_n;
    logic [N-1:0] dig_n;
    logic [4*N-1:0] bcd;
    logic [N-1:0] digit_valid, blank, err;
    logic         upd;
    logic [1:0]   upd_idx;

    always #5 clk = ~clk;

    seg7_capture #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .err_clr     (err_clr),
        .bcd         (bcd),
        .digit_valid (digit_valid),
        .blank       (blank),
        .err         (err),
        .upd         (upd),
        .upd_idx     (upd_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  pats [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                              7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    logic [3:0]  m_bcd [N];
    logic [N-1:0] m_valid, m_blank, m_err;
    logic        m_upd;
    logic [1:0]  m_idx;
    bit          m_ready = 0;
    logic [10:0] m_s1, m_s2;
    logic [10:0] fh[$];

    // Filter commits when the last S filtered samples agree and the one before them differs
    task automatic model_step();
        logic [10:0] f;
        bit          stable;
        int          d, v;
        if (reset) begin
            for (int i = 0; i < N; i++) m_bcd[i] = 4'd0;
            m_valid = '0; m_blank = '0; m_err = '0; m_upd = 0; m_idx = 0;
            m_s1 = '1; m_s2 = '1;
            fh.delete();
            for (int i = 0; i <= S; i++) fh.push_back('1);
            m_ready = 1;
        end else begin
            f    = m_s2;
            m_s2 = m_s1;
            m_s1 = {dig_n, seg_n};
            fh.push_back(f);
            if (fh.size() > S + 1) void'(fh.pop_front());
            stable = (fh[0] != fh[S]);
            for (int j = 1; j < S; j++) if (fh[j] != fh[S]) stable = 0;
            m_upd = 0;
            if (err_clr) m_err = '0;
            if (stable && $countones(~f[10:7]) == 1) begin
                d = 0;
                for (int i = 0; i < N; i++) if (!f[7+i]) d = i;
                v = -1;
                for (int p = 0; p < 10; p++) if (pats[p] == f[6:0]) v = p;
                if (v >= 0) begin
                    m_bcd[d] = 4'(v); m_valid[d] = 1; m_blank[d] = 0;
                end else if (f[6:0] == 7'h7F) begin
                    m_blank[d] = 1; m_valid[d] = 0;
                end else begin
                    m_err[d] = 1; m_valid[d] = 0; m_blank[d] = 0;
                end
                m_upd = 1;
                m_idx = 2'(d);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("bcd",     32'(bcd), 32'({m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]}));
            check("valid",   32'(digit_valid), 32'(m_valid));
            check("blank",   32'(blank), 32'(m_blank));
            check("err",     32'(err), 32'(m_err));
            check("upd",     32'(upd), 32'(m_upd));
            check("upd_idx", 32'(upd_idx), 32'(m_idx));
        end
        if (upd === 1'b1) n_upd++;
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [N-1:0] d, input logic [6:0] s, input int cycles);
        dig_n = d;
        seg_n = s;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int base;
        reset   = 1'b1;
        err_clr = 1'b0;
        seg_n   = 7'($urandom);
        dig_n   = 4'($urandom);
        @(negedge clk);
        seg_n = 7'($urandom);
        dig_n = 4'($urandom);
        @(negedge clk);
        check("rst_bcd",   32'(bcd), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_flags", 32'({blank, err, upd, upd_idx}), 32'h0);
        reset = 1'b0;
        base  = n_upd;
        drive(4'hF, 7'h7F, 4);
        check("no_upd_after_rst", 32'(n_upd - base), 32'd0);

        // Single digit: commit visible six negedges after the change
        dig_n = 4'b1110;
        seg_n = 7'h12;
        repeat (5) @(negedge clk);
        check("lat_upd_early", 32'(upd), 32'd0);
        @(negedge clk);
        check("lat_upd", 32'(upd), 32'd1);
        check("lat_idx", 32'(upd_idx), 32'd0);
        @(negedge clk);
        check("lat_upd_once", 32'(upd), 32'd0);
        repeat (3) @(negedge clk);
        check("d0_bcd",   32'(bcd[3:0]), 32'd2);
        check("d0_valid", 32'(digit_valid), 32'b0001);

        // Scan all four digits
        base = n_upd;
        for (int d = 0; d < N; d++) begin
            drive(~(4'b0001 << d), pats[d], 8);
        end
        drive(4'hF, 7'h7F, 2);
        check("scan_bcd",   32'(bcd), 32'h3210);
        check("scan_valid", 32'(digit_valid), 32'hF);
        check("scan_upds",  32'(n_upd - base), 32'd4);

        // Short glitch on digit 1 must not commit
        drive(4'b1101, 7'h4F, 8);
        base = n_upd;
        drive(4'b1101, 7'h06, 2);
        drive(4'b1101, 7'h4F, 4);
        check("glitch_no_upd", 32'(n_upd - base), 32'd0);
        repeat (6) @(negedge clk);
        check("glitch_bcd", 32'(bcd[7:4]), 32'd1);

        // Blank, then invalid with err_clr colliding on the commit edge
        drive(4'b1011, 7'h7F, 8);
        check("blank_bits", 32'(blank), 32'b0100);
        check("blank_valid", 32'(digit_valid), 32'b1011);
        check("blank_bcd", 32'(bcd[11:8]), 32'd2);
        seg_n = 7'h7E;
        repeat (5) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        check("err_set_wins", 32'(err), 32'b0100);
        check("err_flags", 32'({digit_valid[2], blank[2]}), 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Two selects active: no commit, no change
        base = n_upd;
        drive(4'b1100, 7'h00, 20);
        check("multi_no_upd", 32'(n_upd - base), 32'd0);
        check("multi_bcd",    32'(bcd), 32'h3210);
        check("multi_valid",  32'(digit_valid), 32'b1011);

        // Reset mid-filter abandons the pending commit
        drive(4'b1110, 7'h00, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base  = n_upd;
        drive(4'hF, 7'h7F, 8);
        check("midrst_no_upd", 32'(n_upd - base), 32'd0);
        check("midrst_bcd",    32'(bcd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Recovers BCD digit values from a multiplexed, active-low 7-segment display bus, such as the bus the board drives or an external display module sniffed on GPIO. It synchronises the segment and digit-select lines and applies a stability filter. Each stable pattern is classified as a digit 0–9, blank or invalid, and the result goes into a per-digit register bank. It is the read-back side of the display path, used for self-check and for capturing readings from external counters.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1–8)
- STABLE_CYCLES, 16, consecutive identical synchronised samples required before commit (≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- seg_n  in  7  segment lines, active-low: bit6=a, 5=b, 4=c, 3=d, 2=e, 1=f, 0=g; asynchronous to clk
- dig_n  in  NUM_DIGITS  digit selects, active-low one-hot, bit i = digit i; asynchronous
- err_clr  in  1  clears all sticky err bits
- bcd  out  4*NUM_DIGITS  digit i value in bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  digit i last committed a legal 0–9 pattern
- blank  out  NUM_DIGITS  digit i last committed all-segments-off
- err  out  NUM_DIGITS  sticky, digit i committed an unrecognised pattern
- upd  out  1  one-cycle pulse on every commit
- upd_idx  out  clog2(NUM_DIGITS), min 1  digit index of the current/last commit

## Operation
- Synchroniser:
  - Two flops per line on seg_n and dig_n.
  - obs = {dig_sync, seg_sync}.
- Stability filter:
  - prev_obs register; counter cnt saturating at STABLE_CYCLES.
  - obs ≠ prev_obs: cnt←1, prev_obs←obs.
  - Otherwise cnt increments, with saturation.
  - Commit fires on the edge where cnt goes STABLE_CYCLES-1→STABLE_CYCLES, exactly once per stable period.
  - A held pattern never re-commits.
- Commit gating:
  - Commit happens only if dig_sync has exactly one zero bit; that bit is index i.
  - All-ones dig (no digit) or multiple zeros: no commit, no upd, no state change.
- Pattern table (seg_n, active-low hex):
  - 0=0x01, 1=0x4F, 2=0x12, 3=0x06, 4=0x4C, 5=0x24, 6=0x20, 7=0x0F, 8=0x00, 9=0x04.
  - 6 and 9 are the tailed forms.
  - Blank = 0x7F.
- Commit actions for digit i:
  - Legal digit: bcd[i]←value, digit_valid[i]←1, blank[i]←0.
  - Blank: blank[i]←1, digit_valid[i]←0, bcd[i] held.
  - Any other pattern: err[i]←1, digit_valid[i]←0, blank[i]←0, bcd[i] held.
  - All cases: upd=1 for one cycle, upd_idx←i.
- err_clr:
  - Clears all err bits on the next edge.
  - If a commit sets err[i] on the same edge, set wins for that bit; other bits clear.
- State machine (filter): IDLE (cnt<STABLE_CYCLES) → COMMIT (single edge) → HELD (saturated) → IDLE on any obs change.

## Timing
- Reset:
  - bcd=0, digit_valid=0, blank=0, err=0, upd=0, upd_idx=0, cnt=0.
  - Synchroniser flops and prev_obs set to all ones (no digit, blank).
  - Reset mid-filter abandons the pending commit.
  - Reset also clears sticky err.
- Latency:
  - Input sampled first at edge k and held.
  - dig_sync/seg_sync valid after edge k+1.
  - Commit and outputs update at edge k+STABLE_CYCLES+1.
  - upd is high during the following cycle.
- Filter rejects any glitch shorter than STABLE_CYCLES synchronised samples.
  - Segment and select changes arriving a cycle apart restart the count.
- All outputs are registered; there are no combinational paths from inputs.
- Scan rate constraint: each digit dwell must be ≥ STABLE_CYCLES+3 clk periods, or that digit is never captured. This is the integrator's responsibility.

## Structure
- Shared package seg7_pkg:
  - Segment bit-order constants.
  - The ten digit pattern constants and SEG7_BLANK.
  - So the encoder and this block share one table.
- Sub-module seg7_pattern_decode:
  - Combinational: 7-bit pattern → {kind[1:0] (digit/blank/invalid), value[3:0]}.
  - Reusable elsewhere.
- Top level holds the synchroniser, filter, one-hot check and register bank.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, STABLE_CYCLES=4.

- Reset asserted for 2 cycles with random inputs → all outputs 0; no upd for 4 cycles after release with dig_n=4'hF.
- dig_n=4'b1110, seg_n=0x12 from edge k, held 10 cycles → single upd at edge k+5, upd_idx=0, bcd[3:0]=2, digit_valid=4'b0001.
- Scan digits 0..3 with patterns 0x01, 0x4F, 0x12, 0x06, 8 cycles each → bcd=16'h3210, digit_valid=4'hF, four upd pulses.
- Digit 1 holds 0x4F; seg_n glitches to 0x06 for 2 cycles, then back → no upd, bcd[7:4] stays 1.
- dig_n=4'b1011, seg_n=0x7F → blank[2]=1, digit_valid[2]=0, bcd[11:8] unchanged. Then seg_n=0x7E → err[2]=1. err_clr on the commit edge → err[2] stays 1; err_clr one cycle later → err=0.
- dig_n=4'b1100 with seg_n=0x00 held 20 cycles → no upd, no register change.
